rpn_stack_calc: RTL and testbench
=================================

# rpn_stack_calc

Clocked, parametrised Reverse-Polish-Notation calculator: an operand stack of configurable width and depth with multiply, add, subtract and swap operations, plus pop and clear. Underflow, overflow and arithmetic-overflow conditions are flagged explicitly. The top of stack is converted to BCD by a sequential double-dabble engine and drives one seven-segment digit per decimal place. It sits between the switch/button debouncers and the seven-segment display bank.

## Interface
- `WIDTH`, 8: operand width in bits (≥ 4).
- `DEPTH`, 16: stack entries (≥ 2).
- `DIGITS`, 3: decimal digits displayed; must satisfy 10^DIGITS > 2^WIDTH − 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din` in WIDTH: operand for push.
- `push` in 1: one-cycle pulse; push `din`.
- `op_valid` in 1: one-cycle pulse; execute `op`.
- `op` in 2: 00 = multiply, 01 = add, 10 = subtract, 11 = swap top two.
- `pop` in 1: one-cycle pulse; discard the top entry.
- `clear` in 1: one-cycle pulse; empty the stack.
- `top` out WIDTH: registered top-of-stack value; 0 when empty.
- `count` out $clog2(DEPTH+1): number of valid entries.
- `empty`, `full` out 1: count == 0 / count == DEPTH.
- `arith_ovf` out 1: the last completed arithmetic op truncated or borrowed.
- `err` out 1: sticky command error; cleared only by `clear` or `rst`.
- `err_code` out 2: 00 none, 01 overflow (push when full), 10 underflow (op with count<2, or pop when empty).
- `busy` out 1: BCD conversion in progress.
- `seg` out 7*DIGITS: abcdefg, active-high, digit 0 (units) in bits [6:0].

## Operation
- One command per cycle. If several strobes are high together, priority is `clear` > `pop` > `op_valid` > `push`. Lower-priority strobes in that cycle are dropped silently, with no error.
- Operand naming: a = entry count−2, b = entry count−1 (top).
- Multiply and add: a ← (a op b) truncated to WIDTH; count decrements. `arith_ovf` = 1 if the full-precision result exceeds 2^WIDTH−1.
- Subtract: a ← (a − b) mod 2^WIDTH; count decrements. `arith_ovf` = 1 if b > a (borrow).
- Swap: exchange a and b; count unchanged; `arith_ovf` ← 0.
- Push when full: stack unchanged, `err` ← 1, `err_code` ← 01.
- Op with count < 2, or pop when empty: stack unchanged, `err` ← 1, `err_code` ← 10.
- Invalid commands never change `arith_ovf`.
- Clear: count ← 0, `err` ← 0, `err_code` ← 00, `arith_ovf` ← 0. Storage contents are don't-care; nothing is read above count−1.
- `err_code` holds the most recent error.
- Reset values: count 0, `top` 0, `empty` 1, `full` 0, `arith_ovf` 0, `err` 0, `err_code` 00, `busy` 0, and `seg` showing 0 on all digits (blanking rules in Configuration).
- BCD engine states: IDLE → SHIFT (WIDTH cycles, add-3-then-shift) → DONE (latch digits, update `seg`) → IDLE.
  - A change of `top` starts a conversion.
  - A change of `top` during SHIFT restarts the conversion from the new value.
  - `seg` holds its previous value until DONE.

## Timing
- Command sampled on the rising edge; `top`, `count`, flags and `err` are valid the following cycle (latency 1).
- `busy` rises the cycle after `top` changes. `seg` updates WIDTH+2 cycles after the command edge, and `busy` falls in the same cycle.
- Back-to-back commands on consecutive cycles are legal. Only the final `top` value is guaranteed to reach `seg`.
- `rst` asserted mid-conversion aborts it: `busy` is 0 and `seg` shows 0 the next cycle.

## Configuration
- `RPN_LZ_BLANK_EN` defined: leading-zero digits are blanked (7'b0000000); the units digit is always shown. After reset only the units digit shows 0.
- `RPN_LZ_BLANK_EN` undefined: all DIGITS digits are always driven, including leading zeros.

## Structure
- Package `rpn_pkg`: op encodings, `err_code` encodings, and the digit-to-seven-segment function (0 = 1111110 … 9 = 1110011).
- Sub-module `bin2bcd_seq`: the sequential double-dabble converter. Parameters WIDTH and DIGITS; ports `start`, `bin`, `busy`, `done`, `bcd`.
- Stack storage is a register array indexed by count. `top` is a separate register updated alongside it.

## Test plan
- Reset, then push 12, push 30, op=01 → `top`=42, count=1, `arith_ovf`=0; `seg` shows 0,4,2 (with `RPN_LZ_BLANK_EN`: blank,4,2) after WIDTH+2 cycles.
- Push 20, push 13, op=00 (WIDTH=8) → `top`=4 (260 mod 256), `arith_ovf`=1.
- Push 5, push 9, op=10 → `top`=252, `arith_ovf`=1; then push 7, op=11 → `top`=252 and the entry below it is 7.
- Push DEPTH+1 values → count=DEPTH, `full`=1, `err`=1, `err_code`=01; `top` equals the DEPTH-th value.
- Empty stack, op=01 → `err_code`=10 and count stays 0. Then `clear` and `push` in the same cycle → only the clear takes effect: `err`=0, count=0.
- Push 200, then push 7 one cycle later → after the conversion completes, `seg` shows 007; the conversion for 200 is abandoned on restart and never reaches `seg`.

Source files
------------

// File: rtl/rpn_pkg.sv
// -----------------------------------------------------------------------------
// rpn_pkg
// Shared definitions for the RPN stack calculator:
//   - op_e          : arithmetic / stack operation encodings
//   - err_code_e    : command error encodings reported on err_code
//   - bcd_state_e   : states of the sequential double-dabble converter
//   - digit_to_seg  : BCD digit to active-high abcdefg segment pattern
// -----------------------------------------------------------------------------
package rpn_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_SWAP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_OVERFLOW  = 2'b01,
        ERR_UNDERFLOW = 2'b10,
        ERR_RSVD      = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'b00,
        BCD_SHIFT = 2'b01,
        BCD_DONE  = 2'b10
    } bcd_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Segment order is abcdefg with 'a' in bit 6; non-decimal codes go dark.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1110011;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/rpn_stack_calc_if.sv
// -----------------------------------------------------------------------------
// rpn_stack_calc_if
// Command and status bundle of the RPN calculator.
//   master : drives din/push/op_valid/op/pop/clear, observes status and seg
//   slave  : the calculator itself
// Status: top, count, empty, full, arith_ovf, err, err_code, busy, seg.
// -----------------------------------------------------------------------------
interface rpn_stack_calc_if #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int DIGITS = 3
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]    din;
    logic                push;
    logic                op_valid;
    logic [1:0]          op;
    logic                pop;
    logic                clear;

    logic [WIDTH-1:0]    top;
    logic [CW-1:0]       count;
    logic                empty;
    logic                full;
    logic                arith_ovf;
    logic                err;
    logic [1:0]          err_code;
    logic                busy;
    logic [7*DIGITS-1:0] seg;

    modport master (
        output din, push, op_valid, op, pop, clear,
        input  top, count, empty, full, arith_ovf, err, err_code, busy, seg
    );

    modport slave (
        input  din, push, op_valid, op, pop, clear,
        output top, count, empty, full, arith_ovf, err, err_code, busy, seg
    );
endinterface

// File: rtl/rpn_stack_calc_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble binary-to-BCD converter.
//   clk, rst : clock, synchronous active-high reset
//   start    : load bin and (re)start; accepted in any state
//   bin      : binary value to convert
//   busy     : conversion in progress (SHIFT or DONE)
//   done     : one-cycle strobe, bcd holds the finished result
//   bcd      : DIGITS packed BCD digits, units in [3:0]
// Timeline after start: load, WIDTH add-3-then-shift cycles, one DONE cycle.
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import rpn_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    bcd_state_e      state_q, state_d;
    logic [SW-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // One double-dabble iteration: every BCD nibble >= 5 gets +3, then shift left.
    function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] s);
        logic [SW-1:0] t;
        logic [3:0]    nib;
        t = s;
        for (int i = 0; i < DIGITS; i++) begin
            nib = t[WIDTH + 4*i +: 4];
            if (nib >= 4'd5) begin
                t[WIDTH + 4*i +: 4] = nib + 4'd3;
            end else begin
                t[WIDTH + 4*i +: 4] = nib;
            end
        end
        return {t[SW-2:0], 1'b0};
    endfunction

    // Converter state, working shift register and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BCD_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a start in any state reloads, which gives restart-on-change.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = BCD_SHIFT;
            sreg_d  = {{BW{1'b0}}, bin};
            cnt_d   = '0;
        end else begin
            case (state_q)
                BCD_IDLE: begin
                    state_d = BCD_IDLE;
                end
                BCD_SHIFT: begin
                    sreg_d = dabble_step(sreg_q);
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = BCD_DONE;
                    end else begin
                        state_d = BCD_SHIFT;
                    end
                end
                BCD_DONE: begin
                    state_d = BCD_IDLE;
                end
                default: begin
                    state_d = BCD_IDLE;
                end
            endcase
        end
    end

    // A start arriving in DONE supersedes the result, so done is suppressed.
    assign busy = (state_q != BCD_IDLE);
    assign done = (state_q == BCD_DONE) && !start;
    assign bcd  = sreg_q[SW-1:WIDTH];

endmodule

// File: rtl/rpn_stack_calc.sv
// -----------------------------------------------------------------------------
// rpn_stack_calc
// Reverse-Polish calculator: operand stack with multiply/add/subtract/swap,
// pop and clear, explicit overflow/underflow/arithmetic-overflow flags, and a
// seven-segment rendering of the top of stack via a sequential BCD converter.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : rpn_stack_calc_if.slave (commands in, status and seg out)
// Command priority within a cycle: clear > pop > op_valid > push.
// Build option RPN_LZ_BLANK_EN: blank leading-zero digits (units always shown).
// -----------------------------------------------------------------------------
module rpn_stack_calc
    import rpn_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst,
    rpn_stack_calc_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = 7 * DIGITS;
    localparam int BW = 4 * DIGITS;

    // BCD digits to segment bus, digit 0 (units) in the low 7 bits.
    function automatic logic [SW-1:0] seg_encode(input logic [BW-1:0] bcd);
        logic [SW-1:0] s;
        logic [3:0]    digit;
`ifdef RPN_LZ_BLANK_EN
        logic          lead;
        lead = 1'b1;
`endif
        s = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit = bcd[4*i +: 4];
`ifdef RPN_LZ_BLANK_EN
            if (lead && (digit == 4'd0) && (i != 0)) begin
                s[7*i +: 7] = SEG_BLANK;
            end else begin
                lead        = 1'b0;
                s[7*i +: 7] = digit_to_seg(digit);
            end
`else
            s[7*i +: 7] = digit_to_seg(digit);
`endif
        end
        return s;
    endfunction

    logic [WIDTH-1:0]   stack_q [DEPTH];
    logic [WIDTH-1:0]   stack_d [DEPTH];
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   top_q, top_d;
    logic               arith_ovf_q, arith_ovf_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               empty_q, full_q;
    logic               start_q;
    logic [SW-1:0]      seg_q, seg_d;

    logic [CW-1:0]      cnt_m1_s;
    logic [IW-1:0]      idx_a_s, idx_b_s, idx_push_s;
    logic [WIDTH-1:0]   opa_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     sum_s, diff_s;

    logic               conv_busy_s, conv_done_s;
    logic [BW-1:0]      conv_bcd_s;

    // a sits at count-2, b at count-1; b is always mirrored in top_q.
    assign cnt_m1_s   = count_q - CW'(1);
    assign idx_a_s    = IW'(count_q - CW'(2));
    assign idx_b_s    = IW'(count_q - CW'(1));
    assign idx_push_s = IW'(count_q);
    assign opa_s      = stack_q[idx_a_s];

    assign prod_s = {{WIDTH{1'b0}}, opa_s} * {{WIDTH{1'b0}}, top_q};
    assign sum_s  = {1'b0, opa_s} + {1'b0, top_q};
    assign diff_s = {1'b0, opa_s} - {1'b0, top_q};

    // Command decode: one command per cycle, lower-priority strobes dropped.
    always_comb begin
        stack_d     = stack_q;
        count_d     = count_q;
        top_d       = top_q;
        arith_ovf_d = arith_ovf_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        if (bus.clear) begin
            count_d     = '0;
            top_d       = '0;
            arith_ovf_d = 1'b0;
            err_d       = 1'b0;
            err_code_d  = ERR_NONE;
        end else if (bus.pop) begin
            if (count_q == CW'(0)) begin
                err_d      = 1'b1;
                err_code_d = ERR_UNDERFLOW;
            end else begin
                count_d = cnt_m1_s;
                if (count_q >= CW'(2)) begin
                    top_d = opa_s;
                end else begin
                    top_d = '0;
                end
            end
        end else if (bus.op_valid) begin
            if (count_q < CW'(2)) begin
                err_d      = 1'b1;
                err_code_d = ERR_UNDERFLOW;
            end else begin
                case (bus.op)
                    OP_MUL: begin
                        stack_d[idx_a_s] = prod_s[WIDTH-1:0];
                        top_d            = prod_s[WIDTH-1:0];
                        count_d          = cnt_m1_s;
                        arith_ovf_d      = |prod_s[2*WIDTH-1:WIDTH];
                    end
                    OP_ADD: begin
                        stack_d[idx_a_s] = sum_s[WIDTH-1:0];
                        top_d            = sum_s[WIDTH-1:0];
                        count_d          = cnt_m1_s;
                        arith_ovf_d      = sum_s[WIDTH];
                    end
                    OP_SUB: begin
                        stack_d[idx_a_s] = diff_s[WIDTH-1:0];
                        top_d            = diff_s[WIDTH-1:0];
                        count_d          = cnt_m1_s;
                        arith_ovf_d      = diff_s[WIDTH];
                    end
                    OP_SWAP: begin
                        stack_d[idx_a_s] = top_q;
                        stack_d[idx_b_s] = opa_s;
                        top_d            = opa_s;
                        arith_ovf_d      = 1'b0;
                    end
                    default: begin
                        top_d = top_q;
                    end
                endcase
            end
        end else if (bus.push) begin
            if (count_q == CW'(DEPTH)) begin
                err_d      = 1'b1;
                err_code_d = ERR_OVERFLOW;
            end else begin
                stack_d[idx_push_s] = bus.din;
                top_d               = bus.din;
                count_d             = count_q + CW'(1);
            end
        end else begin
            top_d = top_q;
        end
    end

    // Operand storage: not reset, nothing above count-1 is ever read.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    // Status registers and the conversion trigger (fires on any change of top).
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            top_q       <= '0;
            arith_ovf_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            start_q     <= 1'b0;
            seg_q       <= seg_encode('0);
        end else begin
            count_q     <= count_d;
            top_q       <= top_d;
            arith_ovf_q <= arith_ovf_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            empty_q     <= (count_d == CW'(0));
            full_q      <= (count_d == CW'(DEPTH));
            start_q     <= (top_d != top_q);
            seg_q       <= seg_d;
        end
    end

    // Display holds its value until the converter reports a finished result.
    always_comb begin
        seg_d = seg_q;
        if (conv_done_s) begin
            seg_d = seg_encode(conv_bcd_s);
        end else begin
            seg_d = seg_q;
        end
    end

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start_q),
        .bin   (top_q),
        .busy  (conv_busy_s),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );

    assign bus.top       = top_q;
    assign bus.count     = count_q;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.arith_ovf = arith_ovf_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = conv_busy_s;
    assign bus.seg       = seg_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// -----------------------------------------------------------------------------
// tb_rpn_stack_calc
// Directed stimulus with a reference model; expected status per command and
// expected display per conversion are queued and checked by a monitor.
// -----------------------------------------------------------------------------
module tb_rpn_stack_calc;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int DG = 3;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    rpn_stack_calc_if #(.WIDTH(W), .DEPTH(D), .DIGITS(DG)) bus ();

    rpn_stack_calc #(.WIDTH(W), .DEPTH(D), .DIGITS(DG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  top;
        logic [CW-1:0] count;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          err;
        logic [1:0]    code;
    } status_t;

    typedef struct packed {
        logic [7*DG-1:0] seg;
        int unsigned     edge_no;
    } seg_exp_t;

    status_t  st_q [$];
    seg_exp_t sg_q [$];

    int tests = 0;
    int fails = 0;
    int unsigned edge_n = 0;

    logic [6:0] seg_tbl [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                  7'b1111111, 7'b1110011};

    // reference model
    int unsigned m_stack [D];
    int          m_count;
    logic [W-1:0] m_top;
    logic        m_ovf, m_err;
    logic [1:0]  m_code;
    bit          burst_chg;
    int unsigned chg_edge;

    function automatic logic [7*DG-1:0] seg_of(input int unsigned value);
        logic [7*DG-1:0] s;
        int unsigned dig [DG];
        int unsigned v;
        bit lead;
        v = value;
        for (int i = 0; i < DG; i++) begin
            dig[i] = v % 10;
            v = v / 10;
        end
        s = '0;
        lead = 1'b1;
        for (int i = DG - 1; i >= 0; i--) begin
`ifdef RPN_LZ_BLANK_EN
            if (lead && dig[i] == 0 && i != 0) s[7*i +: 7] = 7'b0000000;
            else begin
                lead = 1'b0;
                s[7*i +: 7] = seg_tbl[dig[i]];
            end
`else
            s[7*i +: 7] = seg_tbl[dig[i]];
`endif
        end
        return s;
    endfunction

    task automatic model_reset();
        m_count = 0; m_top = '0; m_ovf = 1'b0; m_err = 1'b0; m_code = 2'b00;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one command cycle and queue the model's expected status.
    task automatic issue(input bit c, input bit p, input bit v, input logic [1:0] o,
                         input bit u, input logic [W-1:0] d);
        int unsigned a, b, r;
        logic [W-1:0] old_top;
        status_t e;
        @(posedge clk); #1;
        old_top = m_top;
        if (c) begin
            m_count = 0; m_ovf = 1'b0; m_err = 1'b0; m_code = 2'b00;
        end else if (p) begin
            if (m_count == 0) begin m_err = 1'b1; m_code = 2'b10; end
            else m_count--;
        end else if (v) begin
            if (m_count < 2) begin m_err = 1'b1; m_code = 2'b10; end
            else begin
                a = m_stack[m_count-2];
                b = m_stack[m_count-1];
                case (o)
                    2'b00: begin r = a * b; m_ovf = (r > 255); m_stack[m_count-2] = r % 256; m_count--; end
                    2'b01: begin r = a + b; m_ovf = (r > 255); m_stack[m_count-2] = r % 256; m_count--; end
                    2'b10: begin m_ovf = (b > a); m_stack[m_count-2] = (a + 256 - b) % 256; m_count--; end
                    default: begin m_stack[m_count-2] = b; m_stack[m_count-1] = a; m_ovf = 1'b0; end
                endcase
            end
        end else if (u) begin
            if (m_count == D) begin m_err = 1'b1; m_code = 2'b01; end
            else begin m_stack[m_count] = d; m_count++; end
        end
        m_top = (m_count == 0) ? '0 : W'(m_stack[m_count-1]);
        if (m_top != old_top) begin
            burst_chg = 1'b1;
            chg_edge  = edge_n + 1;
        end
        e.top = m_top; e.count = CW'(m_count); e.empty = (m_count == 0); e.full = (m_count == D);
        e.ovf = m_ovf; e.err = m_err; e.code = m_code;
        st_q.push_back(e);
        bus.clear = c; bus.pop = p; bus.op_valid = v; bus.op = o; bus.push = u; bus.din = d;
    endtask

    task automatic do_push(input logic [W-1:0] d); issue(0, 0, 0, 2'b00, 1, d); endtask
    task automatic do_op(input logic [1:0] o);     issue(0, 0, 1, o, 0, '0);    endtask
    task automatic do_pop();                       issue(0, 1, 0, 2'b00, 0, '0); endtask
    task automatic do_clear();                     issue(1, 0, 0, 2'b00, 0, '0); endtask

    task automatic idle_strobes();
        bus.clear = 1'b0; bus.pop = 1'b0; bus.op_valid = 1'b0; bus.push = 1'b0;
        bus.op = 2'b00; bus.din = '0;
    endtask

    // End a back-to-back burst and wait (bounded) for all expectations to drain.
    task automatic finish_burst(input string name);
        seg_exp_t se;
        @(posedge clk); #1;
        idle_strobes();
        if (burst_chg) begin
            se.seg = seg_of(m_top);
            se.edge_no = chg_edge + W + 2;
            sg_q.push_back(se);
        end
        burst_chg = 1'b0;
        for (int i = 0; i < 60 && (sg_q.size() != 0 || st_q.size() != 0); i++) @(negedge clk);
        if (sg_q.size() != 0 || st_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL %s timeout: %0d status and %0d display expectations pending, required 0",
                     name, st_q.size(), sg_q.size());
            st_q.delete(); sg_q.delete();
        end
        @(negedge clk);
    endtask

    // monitor
    logic cmd_prev = 1'b0, rst_prev = 1'b1, busy_prev = 1'b0;
    logic [7*DG-1:0] seg_prev = '0;
    bit mon_en = 1'b0;

    always @(posedge clk) begin
        edge_n   <= edge_n + 1;
        cmd_prev <= bus.push | bus.pop | bus.op_valid | bus.clear;
        rst_prev <= rst;
    end

    always @(negedge clk) begin
        status_t  ex, ac;
        seg_exp_t se;
        if (mon_en && !rst_prev) begin
            if (cmd_prev) begin
                tests++;
                ac.top = bus.top; ac.count = bus.count; ac.empty = bus.empty; ac.full = bus.full;
                ac.ovf = bus.arith_ovf; ac.err = bus.err; ac.code = bus.err_code;
                if (st_q.size() == 0) begin
                    fails++;
                    $display("FAIL status: unexpected command response at edge %0d", edge_n);
                end else begin
                    ex = st_q.pop_front();
                    if (ac !== ex) begin
                        fails++;
                        $display("FAIL status edge %0d: got top=%0d cnt=%0d e=%b f=%b ovf=%b err=%b code=%b, expected top=%0d cnt=%0d e=%b f=%b ovf=%b err=%b code=%b",
                                 edge_n, ac.top, ac.count, ac.empty, ac.full, ac.ovf, ac.err, ac.code,
                                 ex.top, ex.count, ex.empty, ex.full, ex.ovf, ex.err, ex.code);
                    end
                end
            end
            if (busy_prev && !bus.busy) begin
                if (sg_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL seg: unexpected conversion end at edge %0d, seg=%h", edge_n, bus.seg);
                end else begin
                    se = sg_q.pop_front();
                    tests++;
                    if (bus.seg !== se.seg) begin
                        fails++;
                        $display("FAIL seg value: got %h, expected %h", bus.seg, se.seg);
                    end
                    tests++;
                    if (edge_n != se.edge_no) begin
                        fails++;
                        $display("FAIL seg latency: updated at edge %0d, expected edge %0d", edge_n, se.edge_no);
                    end
                end
            end else if (bus.seg !== seg_prev) begin
                tests++; fails++;
                $display("FAIL seg hold: changed to %h without conversion end, was %h", bus.seg, seg_prev);
            end
        end
        busy_prev = bus.busy;
        seg_prev  = bus.seg;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_strobes();
        model_reset();
        burst_chg = 1'b0;
        chg_edge  = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset top", 32'(bus.top), 32'd0);
        chk("reset count", 32'(bus.count), 32'd0);
        chk("reset empty", 32'(bus.empty), 32'd1);
        chk("reset full", 32'(bus.full), 32'd0);
        chk("reset arith_ovf", 32'(bus.arith_ovf), 32'd0);
        chk("reset err", 32'(bus.err), 32'd0);
        chk("reset err_code", 32'(bus.err_code), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset seg", 32'(bus.seg), 32'(seg_of(0)));
        mon_en = 1'b1;

        // 12 + 30 = 42
        do_push(8'd12); do_push(8'd30); do_op(2'b01);
        finish_burst("add");
        // 20 * 13 = 260 -> 4 with overflow
        do_push(8'd20); do_push(8'd13); do_op(2'b00);
        finish_burst("mul");
        // 5 - 9 -> 252 borrow; push 7, swap, pop exposes 7
        do_push(8'd5); do_push(8'd9); do_op(2'b10);
        do_push(8'd7); do_op(2'b11); do_pop();
        finish_burst("sub_swap");
        do_clear();
        finish_burst("clear");
        // fill to DEPTH and one more
        for (int i = 1; i <= D + 1; i++) do_push(8'(i));
        finish_burst("fill");
        do_op(2'b01); do_pop();
        finish_burst("full_add_pop");
        // underflow cases, invalid op keeps arith_ovf, multi-strobe priority
        do_clear(); do_op(2'b01); do_pop();
        do_push(8'd200); do_push(8'd100); do_op(2'b01); do_op(2'b01);
        issue(1, 0, 0, 2'b00, 1, 8'd33);
        issue(0, 1, 0, 2'b00, 1, 8'd44);
        do_clear();
        finish_burst("errors");
        // restart: only 7 reaches the display
        do_push(8'd200); do_push(8'd7);
        finish_burst("restart");
        // op_valid beats push: 200 + 7 = 207
        issue(0, 0, 1, 2'b01, 1, 8'd99);
        finish_burst("op_over_push");

        // reset mid-conversion
        do_push(8'd55);
        @(posedge clk); #1 idle_strobes();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort seg", 32'(bus.seg), 32'(seg_of(0)));
        chk("abort count", 32'(bus.count), 32'd0);
        chk("abort top", 32'(bus.top), 32'd0);
        rst = 1'b0;
        model_reset();
        burst_chg = 1'b0;
        repeat (20) @(negedge clk);
        chk("pending expectations", 32'(st_q.size() + sg_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
